// File: rtl/divider_32_pkg.sv
// Shared types and constants for the iterative restoring divider.
package alu_div_pkg;

    // Legacy-compatible state encoding, shared with the sequencer tooling.
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam int DEF_WIDTH = 32;

    // Quotient reported for a zero divisor: unsigned max, or -1 when signed.
    localparam logic [DEF_WIDTH-1:0] DIV_ZERO_Q = '1;

    // Iteration counter width: must hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/divider_32_if.sv
// Handshake and operand bus between the ALU sequencer and the divider.
interface divider_32_if
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             ena;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dne;
    logic             busy;
    logic             dz;

    modport master (
        output ena, start, sgn, a, b,
        input  q, r, dne, busy, dz
    );

    modport slave (
        input  ena, start, sgn, a, b,
        output q, r, dne, busy, dz
    );

endinterface

// File: rtl/divider_32_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0] rem,
    input  logic           dvd_msb,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_next,
    output logic           q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Shift in the next dividend bit, trial-subtract, keep the trial only if non-negative.
    always_comb begin
        shifted  = {rem, dvd_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/divider_32.sv
// Iterative restoring divider: one quotient bit per enabled clock, signed or unsigned,
// with the same ena/dne handshake as the sequential shift-add multiplier.
module divider_32
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    divider_32_if.slave  bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;       // dividend magnitude, quotient bits shift in at the LSB
    logic [WIDTH:0]   rem;       // partial remainder, one spare bit for the 2^(WIDTH-1) magnitude case
    logic [WIDTH:0]   divisor;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dne_reg;
    logic             busy_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    // Operand magnitudes; the most negative value maps to itself and is read as unsigned.
    always_comb begin
        a_mag = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Control FSM, iteration counter, datapath registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            dne_reg  <= 1'b0;
            busy_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else if (bus.ena) begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd      <= a_mag;
                        divisor  <= {1'b0, b_mag};
                        rem      <= '0;
                        neg_q    <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r    <= bus.sgn & bus.a[WIDTH-1];
                        dz_pend  <= (bus.b == '0);
                        cnt      <= CNT_W'(WIDTH);
                        dne_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor yields an all-ones magnitude; the sign fix would turn it
                    // into +1 for a negative dividend, so the quotient is forced instead.
                    // The remainder needs no special case: re-signing |a| restores a.
                    q_reg    <= dz_pend ? DIV_ZERO_Q : (neg_q ? -dvd : dvd);
                    r_reg    <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    dz_reg   <= dz_pend;
                    dne_reg  <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.dne  = dne_reg;
    assign bus.busy = busy_reg;
    assign bus.dz   = dz_reg;

endmodule

// File: tb/tb_divider_32.sv
// Self-checking bench for divider_32: behavioural reference model compared every cycle,
// directed latency/boundary cases, and randomized operations with enable gaps.
module tb_divider_32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_32_if #(.WIDTH(32)) bus ();

    divider_32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: {quotient, remainder} from plain arithmetic.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == 32'd0) return {32'hFFFFFFFF, a};
        if (!s) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {qq[31:0], rr[31:0]};
    endfunction

    // Behavioural model: accepted starts, fixed latency, held results.
    bit          m_on = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_dne = 1'b0;
    bit          m_dz = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    bit          m_pend_dz = 1'b0;
    int unsigned m_done_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_on   = 1'b1;
            m_busy = 1'b0;
            m_dne  = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dz   = 1'b0;
            m_left = 0;
        end else if (m_on && bus.ena) begin
            if (!m_busy && bus.start) begin
                m_pend    = ref_div(bus.sgn, bus.a, bus.b);
                m_pend_dz = (bus.b == 32'd0);
                m_busy    = 1'b1;
                m_dne     = 1'b0;
                m_left    = 33;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_dne  = 1'b1;
                    m_q    = m_pend[63:32];
                    m_r    = m_pend[31:0];
                    m_dz   = m_pend_dz;
                    m_done_cnt++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            chk("dne",  {31'b0, bus.dne},  {31'b0, m_dne});
            chk("dz",   {31'b0, bus.dz},   {31'b0, m_dz});
            chk("q",    bus.q, m_q);
            chk("r",    bus.r, m_r);
        end
    end

    task automatic run_dir(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input bit gap, input bit poke, input int exp_edges,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int n;
        bit got;
        @(negedge clk);
        bus.ena   = 1'b1;
        bus.sgn   = s;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.dne) got = 1'b1;
            if (n == 1) bus.start = 1'b0;
            if (poke && n == 5) begin
                bus.start = 1'b1;
                bus.a     = 32'd999;
                bus.b     = 32'd1;
            end
            if (poke && n == 6) bus.start = 1'b0;
            if (gap && n == 10) bus.ena = 1'b0;
            if (gap && n == 20) bus.ena = 1'b1;
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s timeout: dne not seen within %0d edges, required %0d", name, n, exp_edges);
        end else begin
            chk({name, " edges"}, 32'(n), 32'(exp_edges));
            chk({name, " q"}, bus.q, eq);
            chk({name, " r"}, bus.r, er);
            chk({name, " dz"}, {31'b0, bus.dz}, {31'b0, edz});
        end
    endtask

    logic [63:0] t;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int unsigned done0;
    int          cyc;

    initial begin
        rst       = 1'b1;
        bus.ena   = 1'b0;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("reset q", bus.q, 32'd0);
        chk("reset dne", {31'b0, bus.dne}, 32'd0);
        rst = 1'b0;

        // Pin the reference model with hand-computed values.
        t = ref_div(1'b1, 32'd100, 32'd7);
        chk("model 100/7", t, {32'd14, 32'd2});
        t = ref_div(1'b1, -32'd100, 32'd7);
        chk("model -100/7 q", t[63:32], 32'hFFFFFFF2);
        chk("model -100/7 r", t[31:0], 32'hFFFFFFFE);
        t = ref_div(1'b1, 32'd100, -32'd7);
        chk("model 100/-7", t, {32'hFFFFFFF2, 32'd2});
        t = ref_div(1'b0, 32'hFFFFFFFF, 32'd2);
        chk("model umax/2", t, {32'h7FFFFFFF, 32'd1});
        t = ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        chk("model ovf", t, {32'h80000000, 32'd0});
        t = ref_div(1'b1, -32'd5, 32'd0);
        chk("model -5/0", t, {32'hFFFFFFFF, 32'hFFFFFFFB});

        // Directed cases with literal expectations.
        run_dir("s 100/7",   1'b1, 32'd100,       32'd7,         0, 0, 34, 32'd14,        32'd2,         1'b0);
        run_dir("s -100/7",  1'b1, -32'd100,      32'd7,         0, 0, 34, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0);
        run_dir("s 100/-7",  1'b1, 32'd100,       -32'd7,        0, 0, 34, 32'hFFFFFFF2,  32'd2,         1'b0);
        run_dir("u max/2",   1'b0, 32'hFFFFFFFF,  32'd2,         0, 0, 34, 32'h7FFFFFFF,  32'd1,         1'b0);
        run_dir("s ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  0, 0, 34, 32'h80000000,  32'd0,         1'b0);
        run_dir("u 5/0",     1'b0, 32'd5,         32'd0,         0, 0, 34, 32'hFFFFFFFF,  32'd5,         1'b1);
        run_dir("s 5/0",     1'b1, 32'd5,         32'd0,         0, 0, 34, 32'hFFFFFFFF,  32'd5,         1'b1);
        run_dir("s -5/0",    1'b1, -32'd5,        32'd0,         0, 0, 34, 32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1);
        run_dir("gap+poke",  1'b1, 32'd100,       32'd7,         1, 1, 44, 32'd14,        32'd2,         1'b0);

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        bus.sgn   = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst q", bus.q, 32'd0);
        chk("rst r", bus.r, 32'd0);
        chk("rst flags", {29'b0, bus.dne, bus.busy, bus.dz}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("rst no dne", {31'b0, bus.dne}, 32'd0);
        run_dir("u 9/3", 1'b0, 32'd9, 32'd3, 0, 0, 34, 32'd3, 32'd0, 1'b0);

        // Randomized operations with enable gaps and ignored starts while busy.
        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = $urandom_range(1, 15);
                4: ra = $urandom_range(0, 100);
                default: ;
            endcase
            @(negedge clk);
            bus.sgn   = rs;
            bus.a     = ra;
            bus.b     = rb;
            bus.start = 1'b1;
            bus.ena   = ($urandom_range(0, 3) != 0);
            done0 = m_done_cnt;
            cyc   = 0;
            while (m_done_cnt == done0 && cyc < 500) begin
                @(negedge clk);
                cyc++;
                if (m_busy) begin
                    bus.start = ($urandom_range(0, 15) == 0);
                    if (bus.start) begin
                        bus.a   = $urandom;
                        bus.b   = $urandom;
                        bus.sgn = 1'($urandom_range(0, 1));
                    end
                end
                bus.ena = ($urandom_range(0, 3) != 0);
            end
            if (m_done_cnt == done0) begin
                n_total++;
                $display("FAIL random op %0d timeout: no completion within %0d cycles", i, cyc);
            end
        end

        @(negedge clk);
        bus.start = 1'b0;
        bus.ena   = 1'b1;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d so far)", n_pass, n_total);
        $fatal(1);
    end

endmodule
